// File: rtl/mem_bist.sv
// March-less pattern BIST for a 32 x 8 synchronous memory: write a pattern to
// every word, read it back through a one-cycle compare pipeline, report results.
module mem_bist #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            pattern_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   MAX_ERRS  = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state;
  logic [1:0]              pat_q;
  logic                    cmp_vld;
  logic [ADDR_WIDTH-1:0]   cmp_addr;
  logic                    err_seen;
  logic                    mismatch;

  // Expected word for address k under pattern sel.
  function automatic logic [DATA_WIDTH-1:0] pat(input logic [1:0]            sel,
                                                 input logic [ADDR_WIDTH-1:0] k);
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] kx;
    logic [DATA_WIDTH-1:0]            alt;
    kx = {{DATA_WIDTH{1'b0}}, k};
    for (int i = 0; i < int'(DATA_WIDTH); i++) alt[i] = ((i % 2) == 0);
    case (sel)
      2'd0:    pat = kx[DATA_WIDTH-1:0];
      2'd1:    pat = k[0] ? ~alt : alt;
      2'd2:    pat = ~kx[DATA_WIDTH-1:0];
      default: pat = {DATA_WIDTH{1'b1}};
    endcase
  endfunction

  assign mismatch = cmp_vld && (mem_rdata != pat(pat_q, cmp_addr));
  assign pass     = done && (err_count == '0);

  // mem_addr doubles as the walking index while in WRITE and READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pat_q          <= '0;
      cmp_vld        <= 1'b0;
      cmp_addr       <= '0;
      err_seen       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees pre-edge values.
      cmp_vld  <= mem_read;
      cmp_addr <= mem_addr;

      if (mismatch) begin
        if (err_count != MAX_ERRS) err_count <= err_count + 1'b1;
        if (!err_seen) begin
          first_err_addr <= cmp_addr;
          err_seen       <= 1'b1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= WRITE;
            pat_q          <= pattern_sel;
            err_count      <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b1;
            mem_write      <= 1'b1;
            mem_addr       <= '0;
            mem_wdata      <= pat(pattern_sel, '0);
          end
        end

        WRITE: begin
          if (mem_addr == LAST_ADDR) begin
            state     <= READ;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            mem_addr  <= mem_addr + 1'b1;
            mem_wdata <= pat(pat_q, mem_addr + 1'b1);
          end
        end

        READ: begin
          if (mem_addr == LAST_ADDR) begin
            state    <= DRAIN;
            mem_read <= 1'b0;
            mem_addr <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end

        DRAIN: begin
          // Last read data is compared this cycle; counters settle before done.
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bist.md
# mem_bist

Built-in self-test initiator for the 32 x 8 synchronous memory on the memory interface. On a start pulse it writes a selected data pattern to every location, reads every location back, and compares each word against the expected value. It reports busy, done, pass, a mismatch count and the first failing address. It sits on the initiator side of the memory interface: it drives write/read/addr/data_in and samples data_out.

## Interface
- ADDR_WIDTH, 5, memory address width.
- DATA_WIDTH, 8, memory word width.
- DEPTH, 32, locations tested (addresses 0..DEPTH-1); DEPTH = 2**ADDR_WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- pattern_sel  in  2  pattern select; latched when start is accepted.
- busy  out  1  high in WRITE, READ and DRAIN.
- done  out  1  high from DONE entry until the next accepted start.
- pass  out  1  done && err_count == 0; low whenever done is low.
- err_count  out  ADDR_WIDTH+1  number of mismatching addresses in the last run.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch; 0 if there is none.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data (data_in).
- mem_rdata  in  DATA_WIDTH  memory read data (data_out); registered, valid one cycle after the read.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- **IDLE / DONE**
  - start=1 → WRITE.
  - On that edge: index=0; pattern_sel latched; err_count, first_err_addr, done and the error-seen flag cleared.
- **WRITE**
  - Outputs: mem_write=1, mem_read=0, mem_addr=index, mem_wdata=pat(index).
  - index increments each cycle.
  - After index DEPTH-1: → READ, index=0.
- **READ**
  - Outputs: mem_write=0, mem_read=1, mem_addr=index.
  - index increments each cycle.
  - After index DEPTH-1: → DRAIN.
- **DRAIN**
  - One cycle; both strobes 0. Completes the compare for the last address.
  - → DONE.
- **DONE**
  - Strobes 0, done=1. Holds until start.
- **Patterns pat(k)** (truncated to DATA_WIDTH):
  - 0: k zero-extended.
  - 1: 0x55 for even k, 0xAA for odd k.
  - 2: ~k (bitwise invert of zero-extended k).
  - 3: all ones.
- **Compare pipeline**
  - Registered cmp_vld and cmp_addr capture "read issued" and mem_addr each READ cycle.
  - In the following cycle, mem_rdata is compared with pat(cmp_addr).
- **On mismatch**
  - err_count increments.
  - If no error has been seen yet in this run: first_err_addr=cmp_addr.
  - err_count max is DEPTH, so it never wraps.
- **Strobe rules**
  - mem_write and mem_read are never both 1.
  - Both are 0 in IDLE, DRAIN and DONE.
- **start handling**
  - start while busy is ignored; there is no queueing.
  - start in DONE restarts the test and clears done on the accepting edge.
- **Reset**
  - rst at any time, including mid-WRITE or mid-READ: immediately → IDLE.
  - All outputs 0; cmp_vld=0.
  - Memory contents are left undefined; no partial result is reported.

## Timing
- **Reset values**
  - busy, done, pass, err_count, first_err_addr: 0.
  - mem_write, mem_read, mem_addr, mem_wdata: 0.
- **Cycle numbering:** cycle 0 is the cycle in which start is sampled.
  - WRITE occupies cycles 1..DEPTH.
  - READ occupies cycles DEPTH+1..2·DEPTH.
  - DRAIN is cycle 2·DEPTH+1.
  - done=1 from cycle 2·DEPTH+2; with defaults, cycles 1–32, 33–64, 65 and 66.
- **Result timing**
  - The compare for the address read in cycle c updates err_count at the end of cycle c+1.
  - Final err_count is stable when done rises.
- **Throughput:** one memory access per cycle; no idle cycle between WRITE and READ.

## Test plan
- **Reset:** assert rst mid-idle → all outputs 0. Hold start=0 for 10 cycles → busy stays 0 and strobes stay 0.
- **Clean run, pattern 0:** pulse start → writes to addr 0..31 with data 0x00..0x1F in cycles 1..32, reads of addr 0..31 in cycles 33..64. At cycle 66: done=1, pass=1, err_count=0, first_err_addr=0.
- **Pattern 1 then pattern 2 back-to-back from DONE:**
  - Pattern 1 → wdata alternates 0x55/0xAA starting at addr 0.
  - Pattern 2 → wdata 0xFF, 0xFE … 0xE0.
  - Both runs: pass=1; done drops on the restart edge.
- **Fault injection:** bench forces mem_rdata bit 0 stuck at 1 when returning addresses 4 and 10, using pattern 0 → err_count=2, first_err_addr=4, pass=0, done=1.
- **Start while busy:** pulse start in cycles 5 and 40 → ignored; done still rises at cycle 66 of the original run.
- **Reset mid-READ:** rst in cycle 45 → busy=0, strobes=0, done=0 immediately. A new start runs clean → pass=1.
